imem_responder: RTL

Responder side of the instruction-fetch interface: accepts fetch addresses from the fetch stage over a valid/ready request channel and returns the addressed 32-bit instruction word over a valid/ready response channel after a fixed latency. It also provides a loader write port so testbenches and boot logic can fill the program store, replacing hard-coded initial contents. It sits between the fetch stage and the program store, and supports full-rate back-to-back fetches with backpressure.

---
 rtl/imem_pkg.sv | 31 +++
 rtl/imem_responder_resp_fifo.sv | 72 +++++++
 rtl/imem_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;

  localparam int IMEM_DEPTH_DEFAULT = 256;

  // Response payload carried through the pipeline and the response FIFO.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [1:0]  err;
  } imem_rsp_t;

  // Error code for a fetch address against a store of 'depth' words.
  // Both bits are set when the address is misaligned and out of range.
  function automatic logic [1:0] imem_err_code(input logic [63:0]  addr,
                                               input int unsigned  depth);
    logic [1:0] err;
    err = 2'b00;
    if (addr[1:0] != 2'b00) begin
      err = err | ERR_MISALIGN;
    end
    if ({2'b00, addr[63:2]} >= 64'(depth)) begin
      err = err | ERR_RANGE;
    end
    return err;
  endfunction

endpackage

// File: rtl/imem_responder_resp_fifo.sv
// Synchronous show-ahead FIFO for responses. The head is valid whenever
// the FIFO is not empty and holds until it is popped.
module resp_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 98
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly since DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next-state pointers and fill count.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; cleared by reset so queued entries are discarded.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; validity is tracked by the count, so no reset here.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: reads the program store at request accept,
// delays the result by LATENCY cycles and returns responses in order
// through a small FIFO. A loader port fills the store.
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH   = IMEM_DEPTH_DEFAULT,
  parameter int LATENCY = 2
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [63:0]              req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [63:0]              rsp_pc,
  output logic [31:0]              rsp_instr,
  output logic [1:0]               rsp_err,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data
);

  localparam int AW     = $clog2(DEPTH);
  localparam int OCC_W  = $clog2(LATENCY + 2);
  localparam int FIFO_D = LATENCY + 1;

  logic [31:0]       store_q [DEPTH];
  logic [AW-1:0]     word_idx;
  logic              accept;
  logic              pop;
  imem_rsp_t         acc_payload;
  logic              push_valid;
  imem_rsp_t         push_data;
  logic              fifo_full, fifo_empty;
  imem_rsp_t         fifo_head;
  logic [OCC_W-1:0]  occ_q, occ_d;

  // Program store, written only by the loader.
  always_ff @(posedge Clk) begin
    // NOTE: the store is deliberately not reset; contents survive reset.
    if (load_en) store_q[load_addr] <= load_data;
  end

  assign word_idx = req_addr[AW+1:2];

  // Loads take priority over fetches; capacity bounds in-flight plus queued.
  assign req_ready = !reset && !load_en && (occ_q < OCC_W'(LATENCY + 1));
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  // Build the response at accept so a later load cannot change it.
  always_comb begin
    acc_payload.pc    = req_addr;
    acc_payload.err   = imem_err_code(req_addr, DEPTH);
    acc_payload.instr = (acc_payload.err == 2'b00) ? store_q[word_idx] : 32'h0;
  end

  // Latency pipeline. The FIFO write is the final stage, so LATENCY-1
  // register stages sit between accept and the FIFO.
  generate
    if (LATENCY == 1) begin : g_direct
      assign push_valid = accept;
      assign push_data  = acc_payload;
    end else begin : g_pipe
      logic [LATENCY-2:0] pipe_valid_q, pipe_valid_d;
      imem_rsp_t          pipe_data_q [LATENCY-1];
      imem_rsp_t          pipe_data_d [LATENCY-1];

      // Shift the accepted payload down the stages.
      always_comb begin
        pipe_valid_d[0] = accept;
        pipe_data_d[0]  = acc_payload;
        for (int i = 1; i < LATENCY - 1; i++) begin
          pipe_valid_d[i] = pipe_valid_q[i-1];
          pipe_data_d[i]  = pipe_data_q[i-1];
        end
      end

      // Valid bits are cleared on reset, dropping in-flight fetches.
      always_ff @(posedge Clk) begin
        if (reset) pipe_valid_q <= '0;
        else       pipe_valid_q <= pipe_valid_d;
      end

      // Payload registers are qualified by the valid bits.
      always_ff @(posedge Clk) begin
        for (int i = 0; i < LATENCY - 1; i++) begin
          pipe_data_q[i] <= pipe_data_d[i];
        end
      end

      assign push_valid = pipe_valid_q[LATENCY-2];
      assign push_data  = pipe_data_q[LATENCY-2];
    end
  endgenerate

  resp_fifo #(
    .DEPTH (FIFO_D),
    .WIDTH ($bits(imem_rsp_t))
  ) u_resp_fifo (
    .clk       (Clk),
    .reset     (reset),
    .push      (push_valid && !fifo_full),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // Occupancy: accepted requests not yet handed to the consumer.
  always_comb begin
    occ_d = occ_q;
    if (accept && !pop)      occ_d = occ_q + 1'b1;
    else if (!accept && pop) occ_d = occ_q - 1'b1;
  end

  // Occupancy register.
  always_ff @(posedge Clk) begin
    if (reset) occ_q <= '0;
    else       occ_q <= occ_d;
  end

  // Outputs read zero whenever no response is present.
  assign rsp_valid = !fifo_empty;
  assign rsp_pc    = rsp_valid ? fifo_head.pc    : 64'h0;
  assign rsp_instr = rsp_valid ? fifo_head.instr : 32'h0;
  assign rsp_err   = rsp_valid ? fifo_head.err   : 2'b00;

endmodule
